// File: rtl/panxi_sram_ctrl.sv
// rtl/panxi_sram_ctrl.sv - Valid/ready command front-end for the single-port SRAM macro wrapper
// PANXI_SRAM_CTRL_RSP_BUF_EN selects a 2-entry response FIFO; default is a single holding register.
module panxi_sram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [31:0]             cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    CEN,
  output logic                    GWEN,
  output logic [DATA_WIDTH-1:0]   AWEN,
  output logic [ADDR_WIDTH-1:0]   AADDR,
  output logic [DATA_WIDTH-1:0]   ADATA_XI,
  input  logic [DATA_WIDTH-1:0]   ADATA_XO
);

  logic                  accept;
  logic                  in_range;
  logic                  access;
  logic                  inflight;
  logic                  inflight_read;
  logic                  inflight_err;
  logic [DATA_WIDTH-1:0] inflight_rdata;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] head_rdata;
  logic                  head_err;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] aaddr_q;
  logic [DATA_WIDTH-1:0] adata_q;
  logic [1:0]            unused_addr_lsb;

  assign unused_addr_lsb = cmd_addr[1:0];

  // Gating with ARESET releases the SRAM pins the moment reset asserts, even mid-cycle.
  assign accept   = cmd_valid & cmd_ready & ~ARESET;
  assign in_range = (cmd_addr[31:ADDR_WIDTH+2] == '0);
  assign access   = accept & in_range;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aaddr_q <= '0;
      adata_q <= '0;
    end else if (access) begin
      aaddr_q <= cmd_addr[ADDR_WIDTH+1:2];
      adata_q <= cmd_wdata;
    end
  end

  always_comb begin
    CEN      = ~access;
    GWEN     = ~(access & cmd_write);
    AWEN     = '1;
    if (access && cmd_write) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        AWEN[8*i +: 8] = {8{~cmd_wstrb[i]}};
      end
    end
    AADDR    = access ? cmd_addr[ADDR_WIDTH+1:2] : aaddr_q;
    ADATA_XI = access ? cmd_wdata : adata_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      inflight      <= 1'b0;
      inflight_read <= 1'b0;
      inflight_err  <= 1'b0;
    end else begin
      inflight      <= accept;
      inflight_read <= accept & ~cmd_write;
      inflight_err  <= accept & ~in_range;
    end
  end

  // SRAM read data is only valid this one cycle, so anything not taken now must be captured.
  assign inflight_rdata = (inflight && inflight_read && !inflight_err) ? ADATA_XO : '0;
  assign pop  = rsp_ready & (fifo_count != 2'd0);
  assign push = inflight & ~(rsp_ready & (fifo_count == 2'd0));

`ifdef PANXI_SRAM_CTRL_RSP_BUF_EN
  localparam logic [1:0] RSP_DEPTH = 2'd2;

  logic [DATA_WIDTH-1:0] fifo_rdata [2];
  logic                  fifo_err   [2];
  logic                  wr_first;

  assign wr_first = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_rdata[i] <= '0;
        fifo_err[i]   <= 1'b0;
      end
    end else begin
      if (pop) begin
        fifo_rdata[0] <= fifo_rdata[1];
        fifo_err[0]   <= fifo_err[1];
      end
      if (push) begin
        if (wr_first) begin
          fifo_rdata[0] <= inflight_rdata;
          fifo_err[0]   <= inflight_err;
        end else begin
          fifo_rdata[1] <= inflight_rdata;
          fifo_err[1]   <= inflight_err;
        end
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_rdata = fifo_rdata[0];
  assign head_err   = fifo_err[0];
  assign cmd_ready  = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
`else
  localparam logic [1:0] RSP_DEPTH = 2'd1;

  logic [DATA_WIDTH-1:0] hold_rdata;
  logic                  hold_err;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      fifo_count <= 2'd0;
      hold_rdata <= '0;
      hold_err   <= 1'b0;
    end else begin
      if (push) begin
        hold_rdata <= inflight_rdata;
        hold_err   <= inflight_err;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_rdata = hold_rdata;
  assign head_err   = hold_err;
  assign cmd_ready  = ~inflight & (fifo_count == 2'd0);
`endif

  assign rsp_valid = inflight | (fifo_count != 2'd0);
  assign rsp_rdata = (fifo_count != 2'd0) ? head_rdata : inflight_rdata;
  assign rsp_err   = (fifo_count != 2'd0) ? head_err : (inflight & inflight_err);

  push_when_full_a: assert property (@(posedge ACLK) disable iff (ARESET)
    !(push && !pop && (fifo_count == RSP_DEPTH)));

endmodule

// File: tb/tb_panxi_sram_ctrl.sv
// tb/tb_panxi_sram_ctrl.sv - Directed self-checking bench for panxi_sram_ctrl with a behavioural SRAM
module tb_panxi_sram_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        CEN, GWEN;
  logic [31:0] AWEN, ADATA_XI;
  logic [9:0]  AADDR;
  logic [31:0] ADATA_XO = 32'h0;

  int          total = 0;
  int          bad = 0;
  int          n_acc, n_rsp, exp_word, n_seen;
  logic        hs;
  logic [31:0] got [3];
  logic [31:0] mem [1024];

`ifdef PANXI_SRAM_CTRL_RSP_BUF_EN
  localparam int EXP_BP_ACC = 2;
  localparam int EXP_TP_ACC = 8;
  localparam int EXP_TP_RSP = 7;
`else
  localparam int EXP_BP_ACC = 1;
  localparam int EXP_TP_ACC = 4;
  localparam int EXP_TP_RSP = 4;
`endif

  panxi_sram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CEN(CEN), .GWEN(GWEN), .AWEN(AWEN), .AADDR(AADDR),
    .ADATA_XI(ADATA_XI), .ADATA_XO(ADATA_XO)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (!CEN) begin
      if (!GWEN) mem[AADDR] <= (mem[AADDR] & AWEN) | (ADATA_XI & ~AWEN);
      else ADATA_XO <= mem[AADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    #1;
    while (!cmd_ready && n < 20) begin
      @(posedge ACLK); #2;
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic accept_edge();
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0; rsp_ready = 1'b1;
    #1 ARESET = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cen", 32'(CEN), 32'd1);
    check("rst_gwen", 32'(GWEN), 32'd1);
    check("rst_awen", AWEN, 32'hFFFF_FFFF);
    check("rst_aaddr", 32'(AADDR), 32'd0);
    check("rst_adata", ADATA_XI, 32'h0);
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, 32'(i * 4), 32'(i + 1), 4'hF);
      accept_edge();
    end
    for (int i = 8; i < 16; i++) begin
      drive_cmd(1'b1, 32'(i * 4), 32'(32'h100 + i), 4'hF);
      accept_edge();
    end

    drive_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    check("wr_cen", 32'(CEN), 32'd0);
    check("wr_gwen", 32'(GWEN), 32'd0);
    check("wr_awen", AWEN, 32'h0);
    check("wr_aaddr", 32'(AADDR), 32'd4);
    check("wr_adata", ADATA_XI, 32'hDEAD_BEEF);
    accept_edge();
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_rsp_err", 32'(rsp_err), 32'd0);
    drive_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    check("rd_cen", 32'(CEN), 32'd0);
    check("rd_gwen", 32'(GWEN), 32'd1);
    check("rd_awen", AWEN, 32'hFFFF_FFFF);
    check("rd_aaddr", 32'(AADDR), 32'd4);
    accept_edge();
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err", 32'(rsp_err), 32'd0);

    drive_cmd(1'b1, 32'h10, 32'h0000_00AA, 4'h1);
    check("bwr_awen", AWEN, 32'hFFFF_FF00);
    accept_edge();
    check("bwr_rsp_err", 32'(rsp_err), 32'd0);
    drive_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    accept_edge();
    check("bwr_rd_rdata", rsp_rdata, 32'hDEAD_BEAA);

    drive_cmd(1'b1, 32'h10, 32'h1234_5678, 4'h0);
    check("zs_cen", 32'(CEN), 32'd0);
    check("zs_gwen", 32'(GWEN), 32'd0);
    check("zs_awen", AWEN, 32'hFFFF_FFFF);
    accept_edge();
    check("zs_rsp_valid", 32'(rsp_valid), 32'd1);
    check("zs_rsp_err", 32'(rsp_err), 32'd0);
    drive_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    accept_edge();
    check("zs_rd_rdata", rsp_rdata, 32'hDEAD_BEAA);

    drive_cmd(1'b0, 32'h1000, 32'h0, 4'h0);
    check("oor_cen", 32'(CEN), 32'd1);
    check("oor_aaddr_hold", 32'(AADDR), 32'd4);
    accept_edge();
    check("oor_rsp_valid", 32'(rsp_valid), 32'd1);
    check("oor_rsp_err", 32'(rsp_err), 32'd1);
    check("oor_rsp_rdata", rsp_rdata, 32'h0);

    drive_cmd(1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF);
    check("top_cen", 32'(CEN), 32'd0);
    check("top_aaddr", 32'(AADDR), 32'h3FF);
    accept_edge();
    check("top_rsp_err", 32'(rsp_err), 32'd0);
    drive_cmd(1'b0, 32'hFFF, 32'h0, 4'h0);
    accept_edge();
    check("top_rd_rdata", rsp_rdata, 32'hCAFE_F00D);
    @(posedge ACLK); #2;

    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; n_acc = 0;
    repeat (4) begin
      hs = cmd_ready;
      @(posedge ACLK); #1;
      if (hs) begin n_acc++; cmd_addr = cmd_addr + 32'd4; end
      #1;
    end
    check("bp_accepts", 32'(n_acc), 32'(EXP_BP_ACC));
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_hold_rdata", rsp_rdata, 32'd1);
    rsp_ready = 1'b1; n_rsp = 0;
    for (int c = 0; c < 20 && n_rsp < 3; c++) begin
      hs = cmd_valid & cmd_ready;
      if (rsp_valid) begin got[n_rsp] = rsp_rdata; n_rsp++; end
      @(posedge ACLK); #1;
      if (hs) begin
        n_acc++; cmd_addr = cmd_addr + 32'd4;
        if (n_acc == 3) cmd_valid = 1'b0;
      end
      #1;
    end
    check("bp_rsp_count", 32'(n_rsp), 32'd3);
    check("bp_rsp0", got[0], 32'd1);
    check("bp_rsp1", got[1], 32'd2);
    check("bp_rsp2", got[2], 32'd3);
    repeat (2) @(posedge ACLK);
    #2;

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; n_acc = 0; n_rsp = 0; exp_word = 8;
    repeat (8) begin
      hs = cmd_ready;
      if (rsp_valid) begin
        check("tp_rdata", rsp_rdata, 32'(32'h100 + exp_word));
        exp_word++; n_rsp++;
      end
      @(posedge ACLK); #1;
      if (hs) begin n_acc++; cmd_addr = cmd_addr + 32'd4; end
      #1;
    end
    cmd_valid = 1'b0;
    check("tp_accepts", 32'(n_acc), 32'(EXP_TP_ACC));
    check("tp_responses", 32'(n_rsp), 32'(EXP_TP_RSP));
    repeat (2) @(posedge ACLK);
    #2;

    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    repeat (3) begin
      hs = cmd_ready;
      @(posedge ACLK); #1;
      if (hs) cmd_addr = cmd_addr + 32'd4;
      #1;
    end
    check("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
    #1 ARESET = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cen", 32'(CEN), 32'd1);
    check("midrst_gwen", 32'(GWEN), 32'd1);
    check("midrst_awen", AWEN, 32'hFFFF_FFFF);
    @(posedge ACLK); #1;
    ARESET = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    n_seen = 0;
    repeat (4) begin
      if (rsp_valid) n_seen++;
      @(posedge ACLK); #2;
    end
    check("postrst_no_stale", 32'(n_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
